// File: rtl/dtm_jtag.sv
// rtl/dtm_jtag.sv - JTAG debug transport module driving a DMI request port
//
// Purpose: oversamples tck/tms/tdi in the clk domain, runs the 16-state
// IEEE 1149.1 TAP and exposes the IDCODE, DTMCS, DMI and BYPASS data
// registers. A DMI Update-DR becomes one dmi_valid/dmi_ready request.
//
// Optional feature: define DTM_TRST_EN to add the active-low trstn input.
//
// Ports:
//   clk, resetn                    system clock, synchronous active-low reset
//   trstn                          (DTM_TRST_EN only) active-low TAP reset
//   tck, tms, tdi                  JTAG inputs, asynchronous to clk
//   tdo                            JTAG data out, registered, updated on tck fall
//   dmi_valid, dmi_ready           DMI request handshake
//   dmi_write, dmi_addr, dmi_wdata DMI request payload
//   dmi_rdata                      DMI read data, stable after the handshake
module dtm_jtag #(
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
  parameter int unsigned ABITS       = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
`ifdef DTM_TRST_EN
  input  logic             trstn,
`endif
  input  logic             tck,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             dmi_valid,
  input  logic             dmi_ready,
  output logic             dmi_write,
  output logic [ABITS-1:0] dmi_addr,
  output logic [31:0]      dmi_wdata,
  input  logic [31:0]      dmi_rdata
);

  localparam int unsigned DMIW = ABITS + 34;
  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} dr_sel_e;

  // ---------------- pin synchronisers and tck edge detect ----------------
  logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
  logic                   tck_last_q;
  logic                   tck_s, tms_s, tdi_s, tck_rise, tck_fall;
  logic                   trst_act;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_last_q <= 1'b0;
    end else begin
      tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], tck};
      tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], tms};
      tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], tdi};
      tck_last_q <= tck_s;
    end
  end

  assign tck_s    = tck_sync_q[SYNC_STAGES-1];
  assign tms_s    = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_last_q;
  assign tck_fall = ~tck_s & tck_last_q;

`ifdef DTM_TRST_EN
  // Resets to 1 so the TAP is not held in reset after resetn releases.
  logic [SYNC_STAGES-1:0] trstn_sync_q;
  always_ff @(posedge clk) begin
    if (!resetn) trstn_sync_q <= '1;
    else         trstn_sync_q <= {trstn_sync_q[SYNC_STAGES-2:0], trstn};
  end
  assign trst_act = ~trstn_sync_q[SYNC_STAGES-1];
`else
  assign trst_act = 1'b0;
`endif

  // ---------------- TAP controller ----------------
  tap_state_e tap_q, tap_d, tap_nxt;

  always_ff @(posedge clk) begin
    if (!resetn) tap_q <= TLR;
    else         tap_q <= tap_d;
  end

  always_comb begin
    tap_nxt = tap_q;
    case (tap_q)
      TLR:     tap_nxt = tms_s ? TLR    : RTI;
      RTI:     tap_nxt = tms_s ? SEL_DR : RTI;
      SEL_DR:  tap_nxt = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  tap_nxt = tms_s ? EX1_DR : SH_DR;
      SH_DR:   tap_nxt = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  tap_nxt = tms_s ? UPD_DR : PAU_DR;
      PAU_DR:  tap_nxt = tms_s ? EX2_DR : PAU_DR;
      EX2_DR:  tap_nxt = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  tap_nxt = tms_s ? SEL_DR : RTI;
      SEL_IR:  tap_nxt = tms_s ? TLR    : CAP_IR;
      CAP_IR:  tap_nxt = tms_s ? EX1_IR : SH_IR;
      SH_IR:   tap_nxt = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  tap_nxt = tms_s ? UPD_IR : PAU_IR;
      PAU_IR:  tap_nxt = tms_s ? EX2_IR : PAU_IR;
      EX2_IR:  tap_nxt = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  tap_nxt = tms_s ? SEL_DR : RTI;
      default: tap_nxt = TLR;
    endcase
    tap_d = tap_q;
    if (trst_act)      tap_d = TLR;
    else if (tck_rise) tap_d = tap_nxt;
  end

  // ---------------- IR and data registers ----------------
  logic [4:0]      ir_q, ir_shift_q, ir_shift_d;
  logic [DMIW-1:0] dr_shift_q, dr_shift_d;
  logic            tdo_q;
  dr_sel_e         dr_sel;
  logic            jtag_rise, upd_dr, upd_ir;

  logic             dmi_valid_q, dmi_write_q, capt_q, discard_q;
  logic [ABITS-1:0] dmi_addr_q, last_addr_q;
  logic [31:0]      dmi_wdata_q, last_rdata_q;
  logic [1:0]       sticky_q;
  logic             busy;
  logic [31:0]      dtmcs_val;
  logic [DMIW-1:0]  dmi_cap;

  always_comb begin
    case (ir_q)
      IR_IDCODE: dr_sel = SEL_IDCODE;
      IR_DTMCS:  dr_sel = SEL_DTMCS;
      IR_DMI:    dr_sel = SEL_DMI;
      default:   dr_sel = SEL_BYPASS;
    endcase
  end

  assign jtag_rise = tck_rise & ~trst_act;
  // Update actions fire on the rising edge that lands in the Update state.
  assign upd_dr    = jtag_rise & (tap_nxt == UPD_DR);
  assign upd_ir    = jtag_rise & (tap_nxt == UPD_IR);

  // In flight spans the launch cycle through the rdata capture cycle.
  assign busy      = dmi_valid_q | capt_q;
  assign dtmcs_val = {17'd0, 3'd1, sticky_q, 6'(ABITS), 4'd1};
  assign dmi_cap   = {last_addr_q, last_rdata_q, busy ? 2'd3 : sticky_q};

  always_comb begin
    dr_shift_d = dr_shift_q;
    ir_shift_d = ir_shift_q;
    if (jtag_rise) begin
      case (tap_q)
        CAP_DR: begin
          case (dr_sel)
            SEL_IDCODE: dr_shift_d = {{(DMIW-32){1'b0}}, IDCODE_VAL};
            SEL_DTMCS:  dr_shift_d = {{(DMIW-32){1'b0}}, dtmcs_val};
            SEL_DMI:    dr_shift_d = dmi_cap;
            default:    dr_shift_d = '0;
          endcase
        end
        SH_DR: begin
          // tdi enters at the MSB of whichever register is selected.
          case (dr_sel)
            SEL_DMI:    dr_shift_d = {tdi_s, dr_shift_q[DMIW-1:1]};
            SEL_BYPASS: dr_shift_d = {{(DMIW-1){1'b0}}, tdi_s};
            default:    dr_shift_d = {{(DMIW-32){1'b0}}, tdi_s, dr_shift_q[31:1]};
          endcase
        end
        CAP_IR:  ir_shift_d = 5'b00001;
        SH_IR:   ir_shift_d = {tdi_s, ir_shift_q[4:1]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ir_q       <= IR_IDCODE;
      ir_shift_q <= '0;
      dr_shift_q <= '0;
      tdo_q      <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      dr_shift_q <= dr_shift_d;
      if (trst_act || tap_q == TLR) ir_q <= IR_IDCODE;
      else if (upd_ir)              ir_q <= ir_shift_q;
      if (trst_act) tdo_q <= 1'b0;
      else if (tck_fall) begin
        if (tap_q == SH_IR)      tdo_q <= ir_shift_q[0];
        else if (tap_q == SH_DR) tdo_q <= dr_shift_q[0];
        else                     tdo_q <= 1'b0;
      end
    end
  end

  // ---------------- DMI request path ----------------
  logic       hs, dmi_upd, dtmcs_upd, launch, hardreset;
  logic [1:0] upd_op;

  assign hs        = dmi_valid_q & dmi_ready;
  assign dmi_upd   = upd_dr & (dr_sel == SEL_DMI);
  assign dtmcs_upd = upd_dr & (dr_sel == SEL_DTMCS);
  assign upd_op    = dr_shift_q[1:0];
  // busy is registered, so an update coinciding with the handshake sees busy.
  assign launch    = dmi_upd & ~busy & (sticky_q == 2'd0) &
                     ((upd_op == 2'd1) | (upd_op == 2'd2));
  assign hardreset = dtmcs_upd & dr_shift_q[17];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dmi_valid_q  <= 1'b0;
      dmi_write_q  <= 1'b0;
      dmi_addr_q   <= '0;
      dmi_wdata_q  <= '0;
      last_addr_q  <= '0;
      last_rdata_q <= '0;
      capt_q       <= 1'b0;
      discard_q    <= 1'b0;
      sticky_q     <= 2'd0;
    end else begin
      if (launch) begin
        dmi_valid_q <= 1'b1;
        dmi_write_q <= (upd_op == 2'd2);
        dmi_addr_q  <= dr_shift_q[DMIW-1:34];
        dmi_wdata_q <= dr_shift_q[33:2];
        last_addr_q <= dr_shift_q[DMIW-1:34];
      end else if (hs) begin
        dmi_valid_q <= 1'b0;
      end
      capt_q <= hs;
      if (capt_q && !dmi_write_q && !discard_q && !hardreset)
        last_rdata_q <= dmi_rdata;
      if (capt_q)                 discard_q <= 1'b0;
      else if (hardreset && busy) discard_q <= 1'b1;
      if (dmi_upd && busy)
        sticky_q <= 2'd3;
      else if (dtmcs_upd && (dr_shift_q[16] || dr_shift_q[17]))
        sticky_q <= 2'd0;
    end
  end

  assign tdo       = tdo_q;
  assign dmi_valid = dmi_valid_q;
  assign dmi_write = dmi_write_q;
  assign dmi_addr  = dmi_addr_q;
  assign dmi_wdata = dmi_wdata_q;

endmodule
